// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the CPU data-memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam int unsigned MAX_ADDR_DEFAULT = 60;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load extraction: selects the leading byte/halfword of a big-endian word and extends it.
import mem_access_pkg::*;

module load_extend (
  input  logic [31:0] word,
  input  size_e       size,
  input  logic        sign,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    unique case (size)
      SIZE_BYTE: data = {{24{sign & word[31]}}, word[31:24]};
      SIZE_HALF: data = {{16{sign & word[31]}}, word[31:16]};
      SIZE_WORD: data = word;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a combinational big-endian data memory.
// Optional alignment faulting is enabled with macro MEM_ACCESS_ALIGN_CHECK_EN.
import mem_access_pkg::*;

module mem_access_unit #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned MAX_ADDR = MAX_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

  state_e            state_q, state_d;
  logic              init_q;
  logic              write_q, write_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              fault_q, fault_d;

  logic [31:0]       load_data;
  logic              misaligned;
  logic              bad_req;

  load_extend u_load_extend (
    .word (mem_rdata),
    .size (size_q),
    .sign (signed_q),
    .data (load_data)
  );

  always_comb begin
    misaligned = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misaligned = (req_size == SIZE_HALF && req_addr[0]) ||
                 (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
`endif
    bad_req = (req_size == SIZE_RSVD) || (req_addr > MAX_A) || misaligned;
  end

  // init_q keeps req_ready low until the first clock edge after reset release
  assign req_ready = init_q && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_ACCESS) begin
      mem_addr = addr_q;
      if (write_q && size_q == SIZE_WORD) begin
        mem_wen   = 1'b1;
        mem_wdata = wdata_q;
      end
    end else if (state_q == ST_WRITE) begin
      mem_addr  = addr_q;
      mem_wen   = 1'b1;
      mem_wdata = merge_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    fault_d  = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          write_d  = req_write;
          size_d   = size_e'(req_size);
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          merge_d  = '0;
          fault_d  = bad_req;
          state_d  = bad_req ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!write_q) begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end else if (size_q == SIZE_WORD) begin
          state_d = ST_RESP;
        end else begin
          // sub-word store: splice new data over the leading bytes of the read word
          merge_d = (size_q == SIZE_BYTE) ? {wdata_q[7:0], mem_rdata[23:0]}
                                          : {wdata_q[15:0], mem_rdata[15:0]};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      init_q   <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merge_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= 1'b1;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_wen;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [64];
  int          wen_cnt = 0;
  logic [31:0] last_wdata = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(6), .MAX_ADDR(60)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = {mem[mem_addr], mem[6'(mem_addr + 6'd1)],
                      mem[6'(mem_addr + 6'd2)], mem[6'(mem_addr + 6'd3)]};

  always @(posedge clk) begin
    if (mem_wen) begin
      wen_cnt    = wen_cnt + 1;
      last_wdata = mem_wdata;
      mem[mem_addr]              <= mem_wdata[31:24];
      mem[6'(mem_addr + 6'd1)]   <= mem_wdata[23:16];
      mem[6'(mem_addr + 6'd2)]   <= mem_wdata[15:8];
      mem[6'(mem_addr + 6'd3)]   <= mem_wdata[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Issues one request, waits for the response (holding rsp_ready low for
  // 'stall' extra cycles), and returns latency, data, fault and wen count.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [5:0] a, input logic [31:0] wd,
                        input int stall, output int lat, output logic [31:0] rd,
                        output logic flt, output int wens);
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    wen_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    rd  = rsp_rdata;
    flt = rsp_fault;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_stall_rdata"}, rsp_rdata, rd);
      check({tag, "_stall_ready"}, {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
    wens = wen_cnt;
  endtask

  int          lat, wens;
  logic [31:0] rd;
  logic        flt;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}     = 32'h99368F7E;
    mem[4] = 8'h5A;
    {mem[8], mem[9], mem[10], mem[11]}   = 32'h017D7840;
    {mem[16], mem[17], mem[18], mem[19]} = 32'h11223344;

    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mem_wen",   {31'b0, mem_wen},   32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    do_req("ld_w0", 1'b0, 2'b10, 1'b0, 6'd0, '0, 0, lat, rd, flt, wens);
    check("ld_w0_data", rd, 32'h99368F7E);
    check("ld_w0_lat", lat, 32'd2);
    check("ld_w0_fault", {31'b0, flt}, 32'd0);

    do_req("ld_sb0", 1'b0, 2'b00, 1'b1, 6'd0, '0, 0, lat, rd, flt, wens);
    check("ld_sb0_data", rd, 32'hFFFFFF99);

    do_req("ld_uh2", 1'b0, 2'b01, 1'b0, 6'd2, '0, 0, lat, rd, flt, wens);
    check("ld_uh2_data", rd, 32'h00008F7E);

    do_req("ld_sh2", 1'b0, 2'b01, 1'b1, 6'd2, '0, 0, lat, rd, flt, wens);
    check("ld_sh2_data", rd, 32'hFFFF8F7E);

    do_req("st_b8", 1'b1, 2'b00, 1'b0, 6'd8, 32'h000000AB, 0, lat, rd, flt, wens);
    check("st_b8_wens", wens, 32'd1);
    check("st_b8_wdata", last_wdata, 32'hAB7D7840);
    check("st_b8_lat", lat, 32'd3);
    check("st_b8_rdata", rd, 32'd0);
    check("st_b8_mem", mem_word(8), 32'hAB7D7840);

    do_req("st_w12", 1'b1, 2'b10, 1'b0, 6'd12, 32'hDEADBEEF, 0, lat, rd, flt, wens);
    check("st_w12_wens", wens, 32'd1);
    check("st_w12_lat", lat, 32'd2);
    check("st_w12_mem", mem_word(12), 32'hDEADBEEF);

    do_req("ld_w61", 1'b0, 2'b10, 1'b0, 6'd61, '0, 0, lat, rd, flt, wens);
    check("ld_w61_fault", {31'b0, flt}, 32'd1);
    check("ld_w61_rdata", rd, 32'd0);
    check("ld_w61_wens", wens, 32'd0);
    check("ld_w61_lat", lat, 32'd1);

    do_req("rsvd", 1'b1, 2'b11, 1'b0, 6'd0, 32'h12345678, 0, lat, rd, flt, wens);
    check("rsvd_fault", {31'b0, flt}, 32'd1);
    check("rsvd_rdata", rd, 32'd0);
    check("rsvd_wens", wens, 32'd0);
    check("rsvd_lat", lat, 32'd1);

    do_req("stall", 1'b0, 2'b10, 1'b0, 6'd0, '0, 5, lat, rd, flt, wens);
    check("stall_data", rd, 32'h99368F7E);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    do_req("st_w2", 1'b1, 2'b10, 1'b0, 6'd2, 32'hCAFEF00D, 0, lat, rd, flt, wens);
    check("st_w2_fault", {31'b0, flt}, 32'd1);
    check("st_w2_wens", wens, 32'd0);
    check("st_w2_lat", lat, 32'd1);
    check("st_w2_mem", mem_word(0), 32'h99368F7E);
`else
    do_req("ld_w1", 1'b0, 2'b10, 1'b0, 6'd1, '0, 0, lat, rd, flt, wens);
    check("ld_w1_data", rd, 32'h368F7E5A);
    check("ld_w1_fault", {31'b0, flt}, 32'd0);
    check("ld_w1_lat", lat, 32'd2);
`endif

    // Reset during WRITE of a halfword store: accept, ACCESS, then WRITE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 6'd16; req_wdata = 32'h00001234;
    wen_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_wen_write", {31'b0, mem_wen}, 32'd1);
    check("rmw_wdata", mem_wdata, 32'h12343344);
    #1 rst = 1'b1;
    #1;
    check("rmw_rst_wen", {31'b0, mem_wen}, 32'd0);
    check("rmw_rst_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("rmw_rst_wen_hold", {31'b0, mem_wen}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rmw_ready_after", {31'b0, req_ready}, 32'd1);
    check("rmw_no_wen", wen_cnt, 32'd0);
    check("rmw_mem", mem_word(16), 32'h11223344);
    repeat (3) begin
      @(posedge clk); #1;
      check("rmw_no_resume", {31'b0, mem_wen}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
